cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle_if.sv | 43 ++++
 rtl/cpu_multicycle.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_multicycle_if.sv
// Bus bundle for cpu_multicycle: the instruction-fetch handshake and the
// data-memory request/response signals. The core sits on the master side.
interface cpu_multicycle_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 32
);
    logic [31:0]       INSTRUCTION;
    logic              INSTR_VALID;
    logic              INSTR_REQ;
    logic [PC_W-1:0]   PC_OUT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [DATA_W-1:0] MEM_ADDRESS;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              BUSYWAIT;

    modport master (
        input  INSTRUCTION,
        input  INSTR_VALID,
        output INSTR_REQ,
        output PC_OUT,
        output MEM_READ,
        output MEM_WRITE,
        output MEM_ADDRESS,
        output MEM_WRITEDATA,
        input  MEM_READDATA,
        input  BUSYWAIT
    );

    modport slave (
        output INSTRUCTION,
        output INSTR_VALID,
        input  INSTR_REQ,
        input  PC_OUT,
        input  MEM_READ,
        input  MEM_WRITE,
        input  MEM_ADDRESS,
        input  MEM_WRITEDATA,
        output MEM_READDATA,
        input  BUSYWAIT
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle CPU core: FETCH -> EXEC (-> MEM) -> FETCH.
// Non-memory instructions commit at the end of EXEC; loads and stores hold
// a registered memory request in MEM until the memory drops BUSYWAIT.
module cpu_multicycle #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 8,
    parameter int PC_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    cpu_multicycle_if.master bus
);
    localparam int RA_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM
    } state_t;

    typedef enum logic [7:0] {
        OP_LOADI = 8'd0,
        OP_MOV   = 8'd1,
        OP_ADD   = 8'd2,
        OP_SUB   = 8'd3,
        OP_AND   = 8'd4,
        OP_OR    = 8'd5,
        OP_J     = 8'd6,
        OP_BEQ   = 8'd7,
        OP_BNE   = 8'd8,
        OP_LWD   = 8'd9,
        OP_LWI   = 8'd10,
        OP_SWD   = 8'd11,
        OP_SWI   = 8'd12
    } opcode_t;

    state_t            state;
    state_t            state_next;

    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] regs [REG_COUNT];

    // Decoded instruction fields
    logic [7:0]        op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] diff;
    logic              zero;
    logic              unused_ir_bits;

    // PC arithmetic
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   br_target;

    // Control produced by the next-state logic
    logic              ir_load;
    logic              pc_load;
    logic [PC_W-1:0]   pc_next;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              mem_start;
    logic              mem_start_wr;
    logic [DATA_W-1:0] mem_start_addr;
    logic [DATA_W-1:0] mem_start_wdata;
    logic              mem_done;

    // Registered memory request
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign op   = ir[7:0];
    assign rd   = ir[8 +: RA_W];
    assign rs1  = ir[16 +: RA_W];
    assign rs2  = ir[24 +: RA_W];
    assign imm  = DATA_W'(ir[31:24]);

    // Only the low RA_W bits of the src1 byte select a register.
    assign unused_ir_bits = ^ir[23:16];

    assign src1 = regs[rs1];
    assign src2 = regs[rs2];
    assign diff = src1 - src2;
    assign zero = (diff == '0);

    assign pc_plus4  = pc + PC_W'(4);
    assign br_off    = {{(PC_W-8){ir[15]}}, ir[15:8]};
    assign br_target = pc_plus4 + (br_off << 2);

    // Next-state, register-write, PC-update and memory-launch decisions.
    always_comb begin
        state_next      = state;
        ir_load         = 1'b0;
        pc_load         = 1'b0;
        pc_next         = pc_plus4;
        reg_we          = 1'b0;
        reg_wdata       = '0;
        mem_start       = 1'b0;
        mem_start_wr    = 1'b0;
        mem_start_addr  = '0;
        mem_start_wdata = '0;
        mem_done        = 1'b0;

        case (state)
            S_FETCH: begin
                if (bus.INSTR_VALID) begin
                    ir_load    = 1'b1;
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                state_next = S_FETCH;
                pc_load    = 1'b1;
                case (op)
                    OP_LOADI: begin
                        reg_we    = 1'b1;
                        reg_wdata = imm;
                    end
                    OP_MOV: begin
                        reg_we    = 1'b1;
                        reg_wdata = src2;
                    end
                    OP_ADD: begin
                        reg_we    = 1'b1;
                        reg_wdata = src1 + src2;
                    end
                    OP_SUB: begin
                        reg_we    = 1'b1;
                        reg_wdata = diff;
                    end
                    OP_AND: begin
                        reg_we    = 1'b1;
                        reg_wdata = src1 & src2;
                    end
                    OP_OR: begin
                        reg_we    = 1'b1;
                        reg_wdata = src1 | src2;
                    end
                    OP_J: begin
                        pc_next = br_target;
                    end
                    OP_BEQ: begin
                        if (zero) begin
                            pc_next = br_target;
                        end
                    end
                    OP_BNE: begin
                        if (!zero) begin
                            pc_next = br_target;
                        end
                    end
                    OP_LWD: begin
                        pc_load        = 1'b0;
                        state_next     = S_MEM;
                        mem_start      = 1'b1;
                        mem_start_addr = src2;
                    end
                    OP_LWI: begin
                        pc_load        = 1'b0;
                        state_next     = S_MEM;
                        mem_start      = 1'b1;
                        mem_start_addr = imm;
                    end
                    OP_SWD: begin
                        pc_load         = 1'b0;
                        state_next      = S_MEM;
                        mem_start       = 1'b1;
                        mem_start_wr    = 1'b1;
                        mem_start_addr  = src2;
                        mem_start_wdata = src1;
                    end
                    OP_SWI: begin
                        pc_load         = 1'b0;
                        state_next      = S_MEM;
                        mem_start       = 1'b1;
                        mem_start_wr    = 1'b1;
                        mem_start_addr  = imm;
                        mem_start_wdata = src1;
                    end
                    default: begin
                    end
                endcase
            end

            S_MEM: begin
                if (!bus.BUSYWAIT) begin
                    mem_done   = 1'b1;
                    pc_load    = 1'b1;
                    state_next = S_FETCH;
                    if (mem_rd) begin
                        reg_we    = 1'b1;
                        reg_wdata = bus.MEM_READDATA;
                    end
                end
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register and program counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir <= '0;
            pc <= '0;
        end else begin
            if (ir_load) begin
                ir <= bus.INSTRUCTION;
            end
            if (pc_load) begin
                pc <= pc_next;
            end
        end
    end

    // Register file: single write port; sources are read combinationally,
    // so an instruction sees pre-write values even when rd equals a source.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs <= '{default: '0};
        end else if (reg_we) begin
            regs[rd] <= reg_wdata;
        end
    end

    // Memory request: launched on the EXEC->MEM edge, held stable through
    // stalls and dropped on the completing edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (mem_start) begin
            mem_rd    <= !mem_start_wr;
            mem_wr    <= mem_start_wr;
            mem_addr  <= mem_start_addr;
            mem_wdata <= mem_start_wdata;
        end else if (mem_done) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end
    end

    assign bus.INSTR_REQ     = (state == S_FETCH);
    assign bus.PC_OUT        = pc;
    assign bus.MEM_READ      = mem_rd;
    assign bus.MEM_WRITE     = mem_wr;
    assign bus.MEM_ADDRESS   = mem_addr;
    assign bus.MEM_WRITEDATA = mem_wdata;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle. Two cores (8-bit/8 regs and
// 16-bit/16 regs) run the same instruction and memory-response stream; an
// instruction-level reference model predicts fetch PCs, fetch spacing and
// memory requests, and a negedge monitor compares the DUT bus against it.
module tb_cpu_multicycle;
    localparam int PC_W = 32;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] instr_drv  = '0;
    logic        ivalid_drv = 1'b0;
    logic        busy_drv   = 1'b0;
    logic [15:0] rdata_drv  = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cpu_multicycle_if #(.DATA_W(8),  .PC_W(PC_W)) bus_a ();
    cpu_multicycle_if #(.DATA_W(16), .PC_W(PC_W)) bus_b ();

    assign bus_a.INSTRUCTION  = instr_drv;
    assign bus_a.INSTR_VALID  = ivalid_drv;
    assign bus_a.BUSYWAIT     = busy_drv;
    assign bus_a.MEM_READDATA = rdata_drv[7:0];
    assign bus_b.INSTRUCTION  = instr_drv;
    assign bus_b.INSTR_VALID  = ivalid_drv;
    assign bus_b.BUSYWAIT     = busy_drv;
    assign bus_b.MEM_READDATA = rdata_drv;

    cpu_multicycle #(.DATA_W(8), .REG_COUNT(8), .PC_W(PC_W)) dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_a.master)
    );

    cpu_multicycle #(.DATA_W(16), .REG_COUNT(16), .PC_W(PC_W)) dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_b.master)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        int          lat;
    } fetch_exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cycles;
        bit          abort;
    } mem_exp_t;

    fetch_exp_t  fq [2][$];
    mem_exp_t    mq [2][$];
    logic [31:0] m_reg  [2][32];
    logic [31:0] m_pc   [2];
    int unsigned m_nreg [2] = '{8, 16};
    logic [31:0] m_mask [2] = '{32'h0000_00FF, 32'h0000_FFFF};
    int          next_lat = 1;
    int          last_acc [2] = '{0, 0};
    int          scnt     [2] = '{0, 0};

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pc[c] = '0;
            for (int r = 0; r < 32; r++) m_reg[c][r] = '0;
        end
    endtask

    // Executes one instruction on model core c; an aborted memory access
    // leaves the architectural state untouched.
    task automatic model_step(input int c, input logic [31:0] ins, input logic [31:0] rdv,
                              input int mcyc, input bit abort);
        logic [31:0] m, a, b, imm, pc4, tgt, nx;
        int unsigned rd, rs1, rs2;
        int          op;
        bit          is_mem;
        mem_exp_t    me;
        m   = m_mask[c];
        op  = int'(ins[7:0]);
        rd  = 32'(ins[15:8])  % m_nreg[c];
        rs1 = 32'(ins[23:16]) % m_nreg[c];
        rs2 = 32'(ins[31:24]) % m_nreg[c];
        a   = m_reg[c][rs1];
        b   = m_reg[c][rs2];
        imm = 32'(ins[31:24]) & m;
        pc4 = m_pc[c] + 32'd4;
        tgt = pc4 + ({{24{ins[15]}}, ins[15:8]} * 32'd4);
        nx  = pc4;
        is_mem    = 1'b0;
        me.wr     = 1'b0;
        me.addr   = '0;
        me.data   = '0;
        me.cycles = mcyc;
        me.abort  = abort;
        case (op)
            0:  m_reg[c][rd] = imm;
            1:  m_reg[c][rd] = b;
            2:  m_reg[c][rd] = (a + b) & m;
            3:  m_reg[c][rd] = (a - b) & m;
            4:  m_reg[c][rd] = a & b;
            5:  m_reg[c][rd] = a | b;
            6:  nx = tgt;
            7:  if (((a - b) & m) == 0) nx = tgt;
            8:  if (((a - b) & m) != 0) nx = tgt;
            9:  begin is_mem = 1'b1; me.addr = b;   if (!abort) m_reg[c][rd] = rdv & m; end
            10: begin is_mem = 1'b1; me.addr = imm; if (!abort) m_reg[c][rd] = rdv & m; end
            11: begin is_mem = 1'b1; me.wr = 1'b1; me.addr = b;   me.data = a; end
            12: begin is_mem = 1'b1; me.wr = 1'b1; me.addr = imm; me.data = a; end
            default: ;
        endcase
        if (is_mem) mq[c].push_back(me);
        if (!abort) m_pc[c] = nx;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input int c, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL core%0d %s actual=0x%0h expected=0x%0h cyc=%0d", c, name, act, exp, cyc);
        end
    endtask

    task automatic mon_core(input int c, input bit req, input bit valid, input logic [31:0] pc,
                            input bit mr, input bit mw, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit bw);
        fetch_exp_t fe;
        mem_exp_t   me;
        if (RESET) begin
            chk(c, "rst_instr_req", 32'(req), 32'd1);
            chk(c, "rst_pc_out", pc, 32'd0);
            chk(c, "rst_mem_read", 32'(mr), 32'd0);
            chk(c, "rst_mem_write", 32'(mw), 32'd0);
            chk(c, "rst_mem_address", addr, 32'd0);
            chk(c, "rst_mem_writedata", wdata, 32'd0);
            if (mq[c].size() != 0) begin
                me = mq[c].pop_front();
                chk(c, "abort_pending_is_abort", 32'(me.abort), 32'd1);
                chk(c, "abort_strobe_cycles", 32'(scnt[c]), 32'(me.cycles));
            end
            scnt[c]     = 0;
            last_acc[c] = cyc;
            return;
        end
        if (req && valid) begin
            if (fq[c].size() == 0) begin
                chk(c, "unexpected_fetch_accept", 32'(fq[c].size()), 32'd1);
            end else begin
                fe = fq[c].pop_front();
                chk(c, "fetch_pc", pc, fe.pc);
                chk(c, "fetch_spacing", 32'(cyc - last_acc[c]), 32'(fe.lat));
            end
            last_acc[c] = cyc;
        end
        if (mr && mw) chk(c, "read_and_write_both_high", 32'(mr & mw), 32'd0);
        if (mr || mw) begin
            if (mq[c].size() == 0) begin
                chk(c, "spurious_mem_strobe", 32'({mr, mw}), 32'd0);
            end else begin
                me = mq[c][0];
                scnt[c]++;
                chk(c, "mem_write_flag", 32'(mw), 32'(me.wr));
                chk(c, "mem_address", addr, me.addr);
                if (me.wr) chk(c, "mem_writedata", wdata, me.data);
                if (!bw) begin
                    chk(c, "mem_strobe_cycles", 32'(scnt[c]), 32'(me.cycles));
                    void'(mq[c].pop_front());
                    scnt[c] = 0;
                end
            end
        end
    endtask

    // Monitor: sample both cores half a cycle away from the active edge.
    always @(negedge CLK) begin
        mon_core(0, bus_a.INSTR_REQ, bus_a.INSTR_VALID, bus_a.PC_OUT, bus_a.MEM_READ,
                 bus_a.MEM_WRITE, 32'(bus_a.MEM_ADDRESS), 32'(bus_a.MEM_WRITEDATA), bus_a.BUSYWAIT);
        mon_core(1, bus_b.INSTR_REQ, bus_b.INSTR_VALID, bus_b.PC_OUT, bus_b.MEM_READ,
                 bus_b.MEM_WRITE, 32'(bus_b.MEM_ADDRESS), 32'(bus_b.MEM_WRITEDATA), bus_b.BUSYWAIT);
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2);
        return {8'(s2), 8'(s1), 8'(d), 8'(op)};
    endfunction

    task automatic junk();
        ivalid_drv = 1'($urandom_range(0, 1));
        instr_drv  = $urandom;
        busy_drv   = 1'($urandom_range(0, 1));
        rdata_drv  = 16'($urandom);
    endtask

    task automatic do_reset(input int n);
        RESET      = 1'b1;
        ivalid_drv = 1'b0;
        busy_drv   = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
        RESET = 1'b0;
        model_reset();
        next_lat = 1;
    endtask

    // Presents one instruction when the cores request it, then plays the
    // EXEC/MEM cycles with junk on ignored inputs. abort_after>0 resets the
    // cores after that many stalled MEM cycles (requires abort_after<stall).
    task automatic issue(input logic [31:0] ins, input int stall, input int gap,
                         input int abort_after, input logic [15:0] rdv);
        fetch_exp_t fe;
        int  b;
        int  op_i;
        bit  is_mem;
        int  mcyc;
        b = 0;
        while (!bus_a.INSTR_REQ) begin
            ivalid_drv = 1'b0;
            @(posedge CLK); #1;
            b++;
            if (b > 20) begin
                checks++;
                errors++;
                $display("FAIL fetch_request_timeout waited=%0d cycles limit=20", b);
                break;
            end
        end
        for (int g = 0; g < gap; g++) begin
            ivalid_drv = 1'b0;
            instr_drv  = $urandom;
            @(posedge CLK); #1;
        end
        op_i   = int'(ins[7:0]);
        is_mem = (op_i >= 9) && (op_i <= 12);
        mcyc   = (abort_after > 0) ? abort_after : stall + 1;
        for (int c = 0; c < 2; c++) begin
            fe.pc  = m_pc[c];
            fe.lat = next_lat + gap;
            fq[c].push_back(fe);
            model_step(c, ins, 32'(rdv), mcyc, abort_after > 0);
        end
        instr_drv  = ins;
        ivalid_drv = 1'b1;
        @(posedge CLK); #1;
        junk();
        @(posedge CLK); #1;
        if (!is_mem) begin
            ivalid_drv = 1'b0;
            next_lat   = 2;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            if (abort_after > 0 && s == abort_after) begin
                do_reset(2);
                return;
            end
            junk();
            busy_drv = 1'b1;
            @(posedge CLK); #1;
        end
        junk();
        busy_drv  = 1'b0;
        rdata_drv = rdv;
        @(posedge CLK); #1;
        ivalid_drv = 1'b0;
        busy_drv   = 1'($urandom_range(0, 1));
        next_lat   = 3 + stall;
    endtask

    initial begin
        int op, st, gp, ab;
        #1;
        do_reset(3);

        // loadi/loadi/sub, then store r3 to expose it
        issue(mk(0, 1, 0, 5), 0, 0, 0, 16'h0);
        issue(mk(0, 2, 0, 3), 0, 0, 0, 16'h0);
        issue(mk(3, 3, 1, 2), 0, 0, 0, 16'h0);
        issue(mk(12, 0, 3, 8'h20), 0, 0, 0, 16'h0);

        // beq/bne at PC 8 with offset -2, equal and unequal operands
        for (int k = 0; k < 4; k++) begin
            do_reset(2);
            issue(mk(0, 1, 0, 7), 0, 0, 0, 16'h0);
            issue(mk(0, 2, 0, (k % 2 == 0) ? 7 : 6), 0, 0, 0, 16'h0);
            issue(mk((k < 2) ? 7 : 8, 8'hFE, 1, 2), 0, 0, 0, 16'h0);
            issue(mk(255, 0, 0, 0), 0, 0, 0, 16'h0);
        end

        // swi with a 3-cycle stall, then lwd without stall and store back
        issue(mk(0, 1, 0, 8'hAA), 0, 0, 0, 16'h0);
        issue(mk(12, 0, 1, 8'h10), 3, 0, 0, 16'h0);
        issue(mk(0, 2, 0, 8'h33), 0, 1, 0, 16'h0);
        issue(mk(9, 4, 0, 2), 0, 0, 0, 16'h005C);
        issue(mk(12, 0, 4, 8'h40), 0, 0, 0, 16'h0);

        // r15 doubling: width and register-count truncation differ per core
        issue(mk(0, 15, 0, 8'hFF), 0, 0, 0, 16'h0);
        issue(mk(2, 15, 15, 15), 0, 0, 0, 16'h0);
        issue(mk(12, 0, 15, 8'h00), 1, 0, 0, 16'h0);

        // reset during a stalled lwd: no write, restart from PC 0
        issue(mk(0, 4, 0, 8'h11), 0, 0, 0, 16'h0);
        issue(mk(0, 2, 0, 3), 0, 0, 0, 16'h0);
        issue(mk(9, 4, 0, 2), 3, 0, 2, 16'h00EE);
        issue(mk(12, 0, 4, 8'h50), 0, 0, 0, 16'h0);

        // randomized stream
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            st = int'($urandom_range(0, 3));
            gp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            ab = 0;
            if (op >= 9 && op <= 12 && st >= 2 && $urandom_range(0, 15) == 0)
                ab = int'($urandom_range(1, st - 1));
            issue(mk(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255))), st, gp, ab, 16'($urandom));
            if ($urandom_range(0, 79) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        issue(mk(255, 0, 0, 0), 0, 0, 0, 16'h0);
        repeat (4) begin @(posedge CLK); #1; end
        for (int c = 0; c < 2; c++) begin
            chk(c, "fetch_queue_drained", 32'(fq[c].size()), 32'd0);
            chk(c, "mem_queue_drained", 32'(mq[c].size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
